mem_arbiter: RTL and testbench

Shares one single-port synchronous memory between the core's instruction-fetch port and its load/store port. It sits between `core` and the unified RAM, replacing the separate ROM/RAM paths. It arbitrates round-robin on conflict, issues one access at a time, and tracks fixed read latency with a down-counter. It returns read data on the requester's own port with a one-cycle valid pulse.

---
 rtl/mem_arbiter.sv | 110 +++++++++++
 tb/tb_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between the
// instruction-fetch and load/store ports; one access in flight, fixed read latency.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ready,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_ready,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_en,
  output logic [DATA_W/8-1:0] m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic [DATA_W-1:0]   m_rdata
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [2:0] CNT_INIT = 3'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, RD_I, RD_D} state_t;
  typedef enum logic {LAST_I, LAST_D} last_t;

  state_t     state_reg, state_next;
  logic [2:0] cnt_reg, cnt_next;
  last_t      last_reg, last_next;

  logic grant_cap;
  logic grant_i;
  logic grant_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 3'd0;
      last_reg  <= LAST_D;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      last_reg  <= last_next;
    end
  end

  // Read data is a pure pass-through; only the rvalid pulses qualify it.
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    last_next  = last_reg;
    i_ready    = 1'b0;
    d_ready    = 1'b0;
    m_en       = 1'b0;
    m_we       = '0;
    m_addr     = i_addr;
    m_wdata    = d_wdata;

    i_rvalid = (state_reg == RD_I) && (cnt_reg == 3'd0);
    d_rvalid = (state_reg == RD_D) && (cnt_reg == 3'd0);

    // The rvalid cycle of a read is also grant-capable, giving back-to-back reads.
    grant_cap = !reset && ((state_reg == IDLE) || (cnt_reg == 3'd0));
    grant_i   = grant_cap && i_req && (!d_req || (last_reg == LAST_D));
    grant_d   = grant_cap && d_req && (!i_req || (last_reg == LAST_I));

    if (grant_i) begin
      i_ready    = 1'b1;
      m_en       = 1'b1;
      m_addr     = i_addr;
      state_next = RD_I;
      cnt_next   = CNT_INIT;
      last_next  = LAST_I;
    end else if (grant_d) begin
      d_ready   = 1'b1;
      m_addr    = d_addr;
      last_next = LAST_D;
      if (d_we) begin
        // An all-zero strobe is acknowledged without touching memory.
        m_en       = (d_wstrb != {STRB_W{1'b0}});
        m_we       = d_wstrb;
        state_next = IDLE;
        cnt_next   = 3'd0;
      end else begin
        m_en       = 1'b1;
        state_next = RD_D;
        cnt_next   = CNT_INIT;
      end
    end else if (state_reg != IDLE) begin
      if (cnt_reg != 3'd0) begin
        cnt_next = cnt_reg - 3'd1;
      end else begin
        state_next = IDLE;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances at read latencies 1, 2 and 4,
// each backed by a small behavioural RAM with the matching read pipeline.
module tb_mem_arbiter;
  localparam int N = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req    [N];
  logic [31:0] i_addr   [N];
  logic        i_ready  [N];
  logic        i_rvalid [N];
  logic [31:0] i_rdata  [N];
  logic        d_req    [N];
  logic        d_we     [N];
  logic [31:0] d_addr   [N];
  logic [31:0] d_wdata  [N];
  logic [3:0]  d_wstrb  [N];
  logic        d_ready  [N];
  logic        d_rvalid [N];
  logic [31:0] d_rdata  [N];
  logic        m_en     [N];
  logic [3:0]  m_we     [N];
  logic [31:0] m_addr   [N];
  logic [31:0] m_wdata  [N];
  logic [31:0] m_rdata  [N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_inst
      localparam int LAT = (gi == 0) ? 1 : (gi == 1) ? 2 : 4;
      logic [31:0] mem  [256];
      logic [31:0] pipe [4];

      mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req[gi]), .i_addr(i_addr[gi]), .i_ready(i_ready[gi]),
        .i_rvalid(i_rvalid[gi]), .i_rdata(i_rdata[gi]),
        .d_req(d_req[gi]), .d_we(d_we[gi]), .d_addr(d_addr[gi]),
        .d_wdata(d_wdata[gi]), .d_wstrb(d_wstrb[gi]), .d_ready(d_ready[gi]),
        .d_rvalid(d_rvalid[gi]), .d_rdata(d_rdata[gi]),
        .m_en(m_en[gi]), .m_we(m_we[gi]), .m_addr(m_addr[gi]),
        .m_wdata(m_wdata[gi]), .m_rdata(m_rdata[gi])
      );

      always @(posedge clk) begin
        if (m_en[gi]) begin
          if (m_we[gi] == 4'b0000) begin
            pipe[0] <= mem[m_addr[gi][9:2]];
          end else begin
            for (int b = 0; b < 4; b++)
              if (m_we[gi][b]) mem[m_addr[gi][9:2]][8*b +: 8] <= m_wdata[gi][8*b +: 8];
          end
        end
        for (int j = 1; j < 4; j++) pipe[j] <= pipe[j-1];
      end

      assign m_rdata[gi] = pipe[LAT-1];
    end
  endgenerate

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    for (int k = 0; k < N; k++) begin
      i_req[k] = 1'b0; i_addr[k] = '0;
      d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0; d_wstrb[k] = '0;
    end
  endtask

  task automatic dreq(input int k, input logic we, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] s);
    d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = a; d_wdata[k] = wd; d_wstrb[k] = s;
  endtask

  initial begin
    reset = 1'b1;
    clr();
    tick(); tick();

    $display("txn reset: requests held high while in reset");
    i_req[0] = 1'b1; dreq(0, 1'b1, 32'h10, 32'h1, 4'hF);
    #1;
    chk("rst_i_ready", 32'(i_ready[0]), 32'd0);
    chk("rst_d_ready", 32'(d_ready[0]), 32'd0);
    chk("rst_m_en", 32'(m_en[0]), 32'd0);
    chk("rst_m_we", 32'(m_we[0]), 32'd0);
    chk("rst_i_rvalid", 32'(i_rvalid[0]), 32'd0);
    chk("rst_d_rvalid", 32'(d_rvalid[0]), 32'd0);
    clr();
    tick();
    reset = 1'b0;
    tick();

    $display("txn k0 write 0x10 <= 0x00500093");
    dreq(0, 1'b1, 32'h10, 32'h00500093, 4'hF);
    #1;
    chk("wr10_d_ready", 32'(d_ready[0]), 32'd1);
    chk("wr10_m_we", 32'(m_we[0]), 32'hF);
    tick(); clr();

    $display("txn k0 fetch 0x10");
    i_req[0] = 1'b1; i_addr[0] = 32'h10;
    #1;
    chk("fetch_i_ready", 32'(i_ready[0]), 32'd1);
    chk("fetch_m_en", 32'(m_en[0]), 32'd1);
    chk("fetch_m_addr", m_addr[0], 32'h10);
    chk("fetch_m_we", 32'(m_we[0]), 32'd0);
    tick(); clr();
    #1;
    chk("fetch_i_rvalid", 32'(i_rvalid[0]), 32'd1);
    chk("fetch_i_rdata", i_rdata[0], 32'h00500093);
    chk("fetch_d_rvalid", 32'(d_rvalid[0]), 32'd0);
    tick();
    chk("fetch_i_rvalid_off", 32'(i_rvalid[0]), 32'd0);

    $display("txn k0 byte write 0x104");
    dreq(0, 1'b1, 32'h104, 32'h11223344, 4'hF);
    #1; tick(); clr();
    dreq(0, 1'b1, 32'h104, 32'hAABBCCDD, 4'b0100);
    #1;
    chk("bw_d_ready", 32'(d_ready[0]), 32'd1);
    chk("bw_m_we", 32'(m_we[0]), 32'b0100);
    chk("bw_m_en", 32'(m_en[0]), 32'd1);
    tick();
    dreq(0, 1'b0, 32'h104, 32'h0, 4'h0);
    #1;
    chk("bw_rd_d_ready", 32'(d_ready[0]), 32'd1);
    tick(); clr();
    #1;
    chk("bw_d_rvalid", 32'(d_rvalid[0]), 32'd1);
    chk("bw_d_rdata", d_rdata[0], 32'h11BB3344);
    tick();

    $display("txn k0 zero-strobe write then conflict");
    i_req[0] = 1'b1; i_addr[0] = 32'h10;
    #1;
    chk("zs_pre_i_ready", 32'(i_ready[0]), 32'd1);
    tick(); clr();
    #1; tick();
    dreq(0, 1'b1, 32'h108, 32'h55, 4'h0);
    #1;
    chk("zs_d_ready", 32'(d_ready[0]), 32'd1);
    chk("zs_m_en", 32'(m_en[0]), 32'd0);
    chk("zs_m_we", 32'(m_we[0]), 32'd0);
    tick(); clr();
    i_req[0] = 1'b1; i_addr[0] = 32'h10; dreq(0, 1'b0, 32'h100, 32'h0, 4'h0);
    #1;
    chk("zs_conf_i_ready", 32'(i_ready[0]), 32'd1);
    chk("zs_conf_d_ready", 32'(d_ready[0]), 32'd0);
    tick(); clr();
    #1; tick();

    $display("txn k0 continuous contention after reset");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    i_req[0] = 1'b1; i_addr[0] = 32'h10; dreq(0, 1'b0, 32'h104, 32'h0, 4'h0);
    for (int n = 0; n < 8; n++) begin
      logic exp_i;
      exp_i = ((n % 2) == 0);
      #1;
      $display("txn k0 contention cycle %0d expect grant %s", n, exp_i ? "I" : "D");
      chk($sformatf("cont%0d_i_ready", n), 32'(i_ready[0]), 32'(exp_i));
      chk($sformatf("cont%0d_d_ready", n), 32'(d_ready[0]), 32'(!exp_i));
      chk($sformatf("cont%0d_i_rvalid", n), 32'(i_rvalid[0]), 32'((n > 0) && !exp_i));
      chk($sformatf("cont%0d_d_rvalid", n), 32'(d_rvalid[0]), 32'((n > 0) && exp_i));
      tick();
    end
    clr();
    #1; tick();

    $display("txn k1 conflict with latency 2");
    dreq(1, 1'b1, 32'h100, 32'hCAFEF00D, 4'hF);
    #1; tick(); clr();
    dreq(1, 1'b1, 32'h20, 32'h12345678, 4'hF);
    #1; tick(); clr();
    i_req[1] = 1'b1; i_addr[1] = 32'h20; dreq(1, 1'b0, 32'h100, 32'h0, 4'h0);
    #1;
    chk("c2_t0_i_ready", 32'(i_ready[1]), 32'd1);
    chk("c2_t0_d_ready", 32'(d_ready[1]), 32'd0);
    chk("c2_t0_m_addr", m_addr[1], 32'h20);
    tick();
    i_req[1] = 1'b0;
    #1;
    chk("c2_t1_d_ready", 32'(d_ready[1]), 32'd0);
    chk("c2_t1_i_rvalid", 32'(i_rvalid[1]), 32'd0);
    tick();
    #1;
    chk("c2_t2_i_rvalid", 32'(i_rvalid[1]), 32'd1);
    chk("c2_t2_i_rdata", i_rdata[1], 32'h12345678);
    chk("c2_t2_d_ready", 32'(d_ready[1]), 32'd1);
    chk("c2_t2_m_addr", m_addr[1], 32'h100);
    tick();
    d_req[1] = 1'b0;
    #1;
    chk("c2_t3_d_rvalid", 32'(d_rvalid[1]), 32'd0);
    tick();
    #1;
    chk("c2_t4_d_rvalid", 32'(d_rvalid[1]), 32'd1);
    chk("c2_t4_d_rdata", d_rdata[1], 32'hCAFEF00D);
    tick(); clr();
    tick();

    $display("txn k2 reset in the middle of a latency-4 read");
    dreq(2, 1'b0, 32'h40, 32'h0, 4'h0);
    #1;
    chk("rm_t0_d_ready", 32'(d_ready[2]), 32'd1);
    tick(); clr();
    #1; tick();
    reset = 1'b1;
    i_req[2] = 1'b1; i_addr[2] = 32'h40; dreq(2, 1'b1, 32'h44, 32'h1, 4'hF);
    #1;
    chk("rm_rst_i_ready", 32'(i_ready[2]), 32'd0);
    chk("rm_rst_d_ready", 32'(d_ready[2]), 32'd0);
    chk("rm_rst_m_en", 32'(m_en[2]), 32'd0);
    chk("rm_rst_m_we", 32'(m_we[2]), 32'd0);
    chk("rm_rst_d_rvalid", 32'(d_rvalid[2]), 32'd0);
    tick();
    reset = 1'b0;
    clr();
    #1;
    chk("rm_t3_d_rvalid", 32'(d_rvalid[2]), 32'd0);
    tick();
    #1;
    chk("rm_t4_d_rvalid", 32'(d_rvalid[2]), 32'd0);
    i_req[2] = 1'b1; i_addr[2] = 32'h40; dreq(2, 1'b0, 32'h44, 32'h0, 4'h0);
    #1;
    chk("rm_conf_i_ready", 32'(i_ready[2]), 32'd1);
    chk("rm_conf_d_ready", 32'(d_ready[2]), 32'd0);
    tick(); clr();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
